// File: rtl/hlsm_job_pkg.sv
// ----------------------------------------------------------------------------
// hlsm_job_pkg
// Shared types and constants for the HLSM job controller slice.
//   hlsm_state_e : controller FSM states (IDLE, LAUNCH, RUN, HOLD)
//   DATA_W_DEF   : default operand / x-result width
//   Z_W_DEF      : default z-result width
//   pack_ops     : packs an operand triple into one FIFO word ({a, b, c})
// ----------------------------------------------------------------------------
package hlsm_job_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int Z_W_DEF    = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      HOLD   = 2'd3
   } hlsm_state_e;

   // Operand triple packing used by the default-width configuration. The top
   // level does the same concatenation inline for arbitrary DATA_W.
   function automatic logic [3*DATA_W_DEF-1:0] pack_ops(
      input logic [DATA_W_DEF-1:0] a,
      input logic [DATA_W_DEF-1:0] b,
      input logic [DATA_W_DEF-1:0] c
   );
      return {a, b, c};
   endfunction

endpackage

// File: rtl/hlsm_job_controller_if.sv
// ----------------------------------------------------------------------------
// hlsm_job_controller_if
// Bundles every non-clock/reset signal of hlsm_job_controller.
//   in_*   : operand triple stream (valid/ready)
//   hlsm_* : Start/Done launch bus and operands/results of the HLSM datapath
//   out_*  : result stream (valid/ready) plus error flag
//   busy   : controller activity indicator
// Modports:
//   slave  : the controller's view (drives in_ready, hlsm_start/a/b/c, out_*)
//   master : the environment's view (producer, HLSM and consumer)
// ----------------------------------------------------------------------------
interface hlsm_job_controller_if
   import hlsm_job_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int Z_W    = Z_W_DEF
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [DATA_W-1:0] in_c;

   logic              hlsm_start;
   logic [DATA_W-1:0] hlsm_a;
   logic [DATA_W-1:0] hlsm_b;
   logic [DATA_W-1:0] hlsm_c;
   logic              hlsm_done;
   logic [Z_W-1:0]    hlsm_z;
   logic [DATA_W-1:0] hlsm_x;

   logic              out_valid;
   logic              out_ready;
   logic [Z_W-1:0]    out_z;
   logic [DATA_W-1:0] out_x;
   logic              out_err;

   logic              busy;

   modport slave (
      input  in_valid, in_a, in_b, in_c,
      input  hlsm_done, hlsm_z, hlsm_x,
      input  out_ready,
      output in_ready,
      output hlsm_start, hlsm_a, hlsm_b, hlsm_c,
      output out_valid, out_z, out_x, out_err,
      output busy
   );

   modport master (
      output in_valid, in_a, in_b, in_c,
      output hlsm_done, hlsm_z, hlsm_x,
      output out_ready,
      input  in_ready,
      input  hlsm_start, hlsm_a, hlsm_b, hlsm_c,
      input  out_valid, out_z, out_x, out_err,
      input  busy
   );

endinterface

// File: rtl/hlsm_job_fifo.sv
// ----------------------------------------------------------------------------
// hlsm_job_fifo
// Synchronous single-clock FIFO for operand triples.
//   Clk, Rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata (ignored when full)
//   wdata    : WIDTH-bit entry
//   pop      : drop the head entry (ignored when empty)
//   rdata    : head entry, valid while !empty
//   count    : occupancy, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module hlsm_job_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];

   // Full is judged on the registered count, so a push offered while full
   // is refused even when a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge Clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/hlsm_job_controller.sv
// ----------------------------------------------------------------------------
// hlsm_job_controller
// Upstream sequencer for the HLS-generated datapath FSM. Buffers operand
// triples, launches one job at a time with a one-cycle Start pulse, holds
// the operands for the run, captures z/x on Done (or a zeroed error result
// on watchdog timeout) and hands the result out over a valid/ready stream.
// Ports:
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : hlsm_job_controller_if.slave (operand stream, HLSM bus,
//              result stream, busy)
// Parameters:
//   DATA_W     : operand and x width
//   Z_W        : z width
//   FIFO_DEPTH : operand FIFO entries (power of two, >= 2)
//   TIMEOUT    : max cycles in RUN before abort (>= 2)
// ----------------------------------------------------------------------------
module hlsm_job_controller
   import hlsm_job_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int Z_W        = Z_W_DEF,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                  Clk,
   input  logic                  Rst,
   hlsm_job_controller_if.slave  bus
);

   localparam int OPS_W = 3 * DATA_W;
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // FIFO side
   logic [OPS_W-1:0] fifo_rdata;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;

   // FSM, watchdog, operand and result registers
   hlsm_state_e       state_q,     state_d;
   logic [WD_W-1:0]   wdog_q,      wdog_d;
   logic [OPS_W-1:0]  ops_q,       ops_d;
   logic              start_q,     start_d;
   logic              out_valid_q, out_valid_d;
   logic [Z_W-1:0]    out_z_q,     out_z_d;
   logic [DATA_W-1:0] out_x_q,     out_x_d;
   logic              out_err_q,   out_err_d;

   hlsm_job_fifo #(
      .WIDTH (OPS_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk   (Clk),
      .Rst   (Rst),
      .push  (bus.in_valid),
      .wdata ({bus.in_a, bus.in_b, bus.in_c}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      wdog_d      = wdog_q;
      ops_d       = ops_q;
      start_d     = 1'b0;
      out_valid_d = out_valid_q;
      out_z_d     = out_z_q;
      out_x_d     = out_x_q;
      out_err_d   = out_err_q;
      fifo_pop    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               ops_d    = fifo_rdata;
               // Start is registered so it is high for the whole LAUNCH cycle.
               start_d  = 1'b1;
               state_d  = LAUNCH;
            end
         end

         LAUNCH: begin
            wdog_d  = '0;
            state_d = RUN;
         end

         RUN: begin
            wdog_d = wdog_q + WD_W'(1);
            // Done takes priority over a coincident timeout.
            if (bus.hlsm_done) begin
               out_z_d     = bus.hlsm_z;
               out_x_d     = bus.hlsm_x;
               out_err_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
               out_z_d     = '0;
               out_x_d     = '0;
               out_err_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end
         end

         HOLD: begin
            // No new launch until the result is taken, so nothing is lost.
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         wdog_q      <= '0;
         ops_q       <= '0;
         start_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_z_q     <= '0;
         out_x_q     <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wdog_q      <= wdog_d;
         ops_q       <= ops_d;
         start_q     <= start_d;
         out_valid_q <= out_valid_d;
         out_z_q     <= out_z_d;
         out_x_q     <= out_x_d;
         out_err_q   <= out_err_d;
      end
   end

   assign bus.in_ready   = !fifo_full;
   assign bus.hlsm_start = start_q;
   assign bus.hlsm_a     = ops_q[3*DATA_W-1:2*DATA_W];
   assign bus.hlsm_b     = ops_q[2*DATA_W-1:DATA_W];
   assign bus.hlsm_c     = ops_q[DATA_W-1:0];
   assign bus.out_valid  = out_valid_q;
   assign bus.out_z      = out_z_q;
   assign bus.out_x      = out_x_q;
   assign bus.out_err    = out_err_q;
   assign bus.busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: doc/hlsm_job_controller.md
# hlsm_job_controller

Upstream sequencer for the HLS-generated datapath state machine (Start/Done, operands a/b/c, results z/x). Accepts operand triples over a valid/ready stream and buffers them in a small FIFO. Launches one HLSM job at a time with a single-cycle Start pulse, holds operands stable for the run, and captures z/x on Done into a result register. Results leave over a valid/ready stream, and a watchdog flags hung jobs.

## Interface
Parameters:
- DATA_W, 16, operand width and x result width
- Z_W, 8, z result width
- FIFO_DEPTH, 4, operand FIFO entries (power of two, ≥2)
- TIMEOUT, 64, max cycles in RUN before abort (≥2)

Ports:
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand triple valid
- in_ready  out  1  FIFO not full
- in_a, in_b, in_c  in  DATA_W each  operands
- hlsm_start  out  1  one-cycle launch pulse to HLSM
- hlsm_a, hlsm_b, hlsm_c  out  DATA_W each  operands to HLSM, stable LAUNCH..end of RUN
- hlsm_done  in  1  HLSM completion level
- hlsm_z  in  Z_W  HLSM z result
- hlsm_x  in  DATA_W  HLSM x result
- out_valid  out  1  result register full
- out_ready  in  1  consumer accepts
- out_z  out  Z_W  captured z
- out_x  out  DATA_W  captured x
- out_err  out  1  result produced by timeout abort (z/x = 0)
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- FIFO push on in_valid && in_ready. in_ready = (count < FIFO_DEPTH), from registered count. A push offered when full is refused even if a pop occurs in the same cycle. Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into operand register and go to LAUNCH.
  - LAUNCH: hlsm_start=1 for exactly this cycle, clear watchdog, go to RUN.
  - RUN: watchdog increments each cycle. If hlsm_done=1, capture hlsm_z/hlsm_x, out_err=0, go to HOLD. Else, if watchdog = TIMEOUT-1, load z=0, x=0, out_err=1, go to HOLD.
  - HOLD: out_valid=1. On out_ready, go to IDLE.
- hlsm_done is ignored outside RUN, so stale Done from a prior job cannot complete a new one.
- Done and timeout in the same cycle: Done wins, out_err=0.
- Only one job is in flight. The next launch waits for result handoff, so there is no result loss under backpressure.
- Operand register holds values after RUN; hlsm_a/b/c change only on pop.
- Reset values: in_ready=1, hlsm_start=0, hlsm_a/b/c=0, out_valid=0, out_z=0, out_x=0, out_err=0, busy=0. FIFO is emptied, FSM goes to IDLE, watchdog=0.
- Reset mid-RUN discards the in-flight job and all buffered operands. The next job after reset gets a fresh Start.

## Timing
- Push accepted at edge N: FIFO non-empty after N, so IDLE pops at edge N+1. hlsm_start is high between edges N+1 and N+2.
- Done sampled high at edge M (in RUN): out_valid high from M. Handshake at edge K (out_valid && out_ready) returns to IDLE. Next pop is at K+1.
- Minimum job period: 4 cycles plus HLSM run length.
- Timeout: out_err result appears TIMEOUT cycles after entering RUN.
- out_* are registered, with no combinational path from in_* or out_ready to out_*.

## Structure
- Package hlsm_job_pkg holds the FSM state enum (IDLE, LAUNCH, RUN, HOLD) and default DATA_W/Z_W constants.
- Sub-module hlsm_job_fifo is a synchronous FIFO (width 3×DATA_W, depth FIFO_DEPTH) with push/pop/count/full/empty.
- The top level holds the FSM, watchdog counter, operand register and result register.

## Test plan
Bench uses a behavioural HLSM stub: d=a+b, e=a+c, z=(d>e)?d:e truncated to Z_W, x=a*c−d (mod 2^DATA_W). Done is asserted a configurable number of cycles after Start.
- Single job a=3,b=4,c=5, stub latency 6 → one hlsm_start pulse; out_z=8, out_x=8, out_err=0.
- Job a=10,b=20,c=1 → out_z=30, out_x=16'hFFEC.
- Push 5 triples back-to-back with consumer ready, FIFO_DEPTH=4 → in_ready low after the 4th push while no pop has occurred. All 5 results are in order with no duplicates.
- out_ready held low 20 cycles after the first result → no second hlsm_start until the handshake. out_z/out_x stay stable.
- Stub never asserts Done, TIMEOUT=64 → out_err=1, z=0, x=0 exactly 64 cycles after RUN entry. A stale Done later in IDLE is ignored.
- Rst asserted mid-RUN with 2 triples queued → all outputs at reset values next cycle, busy=0. No result is emitted for discarded jobs.
